// File: rtl/serial_comp_if.sv
// serial_comp_if: request/operand/result bundle for serial_comp_ctrl.
// Macro SERIAL_COMP_OVF_EN adds the ovf result flag.
interface serial_comp_if;
    logic [1:0] req;
    logic [8:0] a0;
    logic [8:0] a1;
    logic [1:0] gnt;
    logic       busy;
    logic       valid;
    logic       id;
    logic [8:0] o;
`ifdef SERIAL_COMP_OVF_EN
    logic       ovf;
    modport master (output req, a0, a1, input gnt, busy, valid, id, o, ovf);
    modport slave  (input req, a0, a1, output gnt, busy, valid, id, o, ovf);
`else
    modport master (output req, a0, a1, input gnt, busy, valid, id, o);
    modport slave  (input req, a0, a1, output gnt, busy, valid, id, o);
`endif
endinterface

// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: two-requester round-robin bit-serial two's complement negator.
// Macro SERIAL_COMP_OVF_EN adds the ovf flag for operand 9'h100.
module serial_comp_ctrl (
    input logic         clk,
    input logic         rst,
    serial_comp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
    state_e     state_q, state_d;
    logic [8:0] op_q, op_d, res_q, res_d, o_q, o_d;
    logic [3:0] cnt_q, cnt_d;
    logic       seen_q, seen_d, own_q, own_d, last_q, last_d, id_q, id_d, pick;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            o_q     <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            own_q   <= own_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end
    // on a tie the requester other than the last winner goes next
    assign pick = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        own_d   = own_q;
        last_d  = last_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d = LOAD;
                own_d   = pick;
                last_d  = pick;
                op_d    = pick ? bus.a1 : bus.a0;
                res_d   = '0;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                res_d  = {op_q[0] ^ seen_q, res_q[8:1]};
                seen_d = seen_q | op_q[0];
                op_d   = op_q >> 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    state_d = DONE;
                    o_d     = res_d;
                    id_d    = own_q;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.gnt   = (state_q == LOAD) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.busy  = state_q != IDLE;
    assign bus.valid = state_q == DONE;
    assign bus.id    = id_q;
    assign bus.o     = o_q;
`ifdef SERIAL_COMP_OVF_EN
    // only -256 negates to itself with the sign bit set
    assign bus.ovf   = (state_q == DONE) && (o_q == 9'h100);
`endif
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb_serial_comp_ctrl: random two-requester traffic checked against a transaction-level model.
module tb_serial_comp_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_ok = 0;
    serial_comp_if bus ();
    serial_comp_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int   t = 0;
    int   win = 0;
    int   last = 1;
    int   op = 0;
    int   eo = 0;
    int   eid = 0;
    bit   pend [2];
    int   opv [2];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask
    function automatic int pick_op();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 256;
            2: return 1;
            default: return int'($urandom_range(0, 511));
        endcase
    endfunction
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            t = 0; eo = 0; eid = 0; last = 1;
        end else if (t == 0) begin
            if (bus.req != 2'b00) begin
                win  = (bus.req == 2'b11) ? 1 - last : int'(bus.req[1]);
                last = win;
                op   = win == 1 ? int'(bus.a1) : int'(bus.a0);
                t    = 1;
            end
        end else begin
            t = (t == 11) ? 0 : t + 1;
            if (t == 11) begin
                eo  = (512 - op) % 512;
                eid = win;
            end
        end
        #1;
        chk("gnt", 32'(bus.gnt), (t == 1) ? 32'(1 << win) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(t != 0));
        chk("valid", 32'(bus.valid), 32'(t == 11));
        chk("o", 32'(bus.o), 32'(eo));
        chk("id", 32'(bus.id), 32'(eid));
`ifdef SERIAL_COMP_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(t == 11 && op == 256));
`endif
        if (t == 11) pend[win] = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.req = 2'b00;
        bus.a0 = '0;
        bus.a1 = '0;
        tick();
        tick();
        rst = 1'b0;
        pend[0] = 1'b1; opv[0] = 1;
        pend[1] = 1'b1; opv[1] = 9'h0F0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    opv[i] = pick_op();
                end
            bus.req = {pend[1], pend[0]};
            bus.a0 = (pend[0] && !(t != 0 && win == 0)) ? 9'(opv[0]) : 9'($urandom);
            bus.a1 = (pend[1] && !(t != 0 && win == 1)) ? 9'(opv[1]) : 9'($urandom);
            tick();
        end
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
